// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing a single-port data memory between the memory-access
// stage (MA) and the debug/loader port (DB), with bounded-burst fairness.
module dmem_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ma_req,
  input  logic              ma_we,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_wdata,
  output logic              ma_gnt,
  output logic              ma_rvalid,
  output logic [DATA_W-1:0] ma_rdata,
  input  logic              db_req,
  input  logic              db_we,
  input  logic [ADDR_W-1:0] db_addr,
  input  logic [DATA_W-1:0] db_wdata,
  output logic              db_gnt,
  output logic              db_rvalid,
  output logic [DATA_W-1:0] db_rdata,
  output logic              clka,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta
);

  localparam int              CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic {
    OWN_MA = 1'b0,
    OWN_DB = 1'b1
  } owner_e;

  owner_e           owner_r;
  owner_e           owner_nxt_s;
  owner_e           gnt_port_s;
  logic [CNT_W-1:0] burst_cnt_r;
  logic [CNT_W-1:0] burst_cnt_nxt_s;
  logic             gnt_ma_s;
  logic             gnt_db_s;
  logic             any_gnt_s;

  // Grant decision: a lone requester always wins; under contention the owner keeps the port until its burst is spent.
  always_comb begin
    gnt_ma_s = 1'b0;
    gnt_db_s = 1'b0;
    case ({ma_req, db_req})
      2'b10: gnt_ma_s = 1'b1;
      2'b01: gnt_db_s = 1'b1;
      2'b11: begin
        if (burst_cnt_r < CNT_MAX) begin
          gnt_ma_s = (owner_r == OWN_MA);
          gnt_db_s = (owner_r == OWN_DB);
        end else begin
          gnt_ma_s = (owner_r == OWN_DB);
          gnt_db_s = (owner_r == OWN_MA);
        end
      end
      default: begin
        gnt_ma_s = 1'b0;
        gnt_db_s = 1'b0;
      end
    endcase
  end

  assign any_gnt_s  = gnt_ma_s | gnt_db_s;
  assign gnt_port_s = gnt_db_s ? OWN_DB : OWN_MA;

  // Next owner/burst count: an idle cycle clears the burst so the owner starts a fresh one.
  always_comb begin
    owner_nxt_s     = owner_r;
    burst_cnt_nxt_s = burst_cnt_r;
    if (!any_gnt_s) begin
      burst_cnt_nxt_s = CNT_ZERO;
    end else if (gnt_port_s == owner_r) begin
      if (burst_cnt_r < CNT_MAX) begin
        burst_cnt_nxt_s = burst_cnt_r + CNT_ONE;
      end else begin
        burst_cnt_nxt_s = burst_cnt_r;
      end
    end else begin
      owner_nxt_s     = gnt_port_s;
      burst_cnt_nxt_s = CNT_ONE;
    end
  end

  // Memory pin mux: with no grant the pins idle on MA's address/data.
  always_comb begin
    ena = any_gnt_s;
    if (gnt_db_s) begin
      addra = db_addr;
      dina  = db_wdata;
      wea   = db_we;
    end else begin
      addra = ma_addr;
      dina  = ma_wdata;
      wea   = gnt_ma_s & ma_we;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r     <= OWN_MA;
      burst_cnt_r <= CNT_ZERO;
    end else begin
      owner_r     <= owner_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
    end
  end

  // Read-valid strobes track the one-cycle memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_rvalid <= 1'b0;
      db_rvalid <= 1'b0;
    end else begin
      ma_rvalid <= gnt_ma_s & ~ma_we;
      db_rvalid <= gnt_db_s & ~db_we;
    end
  end

  assign ma_gnt   = gnt_ma_s;
  assign db_gnt   = gnt_db_s;
  assign ma_rdata = douta;
  assign db_rdata = douta;
  assign clka     = clk;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural memory sits on the pins,
// expected read data is queued per port at grant time and matched on rvalid.
module tb_dmem_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int MB     = 4;

  logic              clk;
  logic              rst_n;
  logic              ma_req, ma_we, ma_gnt, ma_rvalid;
  logic [ADDR_W-1:0] ma_addr;
  logic [DATA_W-1:0] ma_wdata, ma_rdata;
  logic              db_req, db_we, db_gnt, db_rvalid;
  logic [ADDR_W-1:0] db_addr;
  logic [DATA_W-1:0] db_wdata, db_rdata;
  logic              clka, ena, wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina, douta;

  logic [DATA_W-1:0] mem    [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
  logic              init_mem;
  logic [DATA_W-1:0] ma_q[$];
  logic [DATA_W-1:0] db_q[$];
  int                n_vec;
  int                n_err;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .ma_gnt(ma_gnt), .ma_rvalid(ma_rvalid), .ma_rdata(ma_rdata),
    .db_req(db_req), .db_we(db_we), .db_addr(db_addr), .db_wdata(db_wdata),
    .db_gnt(db_gnt), .db_rvalid(db_rvalid), .db_rdata(db_rdata),
    .clka(clka), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first single-port memory model; preloaded with a recognisable pattern.
  always @(posedge clka) begin
    if (init_mem) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 32'hA500_0000 + 32'(i);
    end else if (ena) begin
      if (wea) mem[addra] <= dina;
      douta <= mem[addra];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle with the inputs already driven: check grants/pins, score read returns, advance.
  task automatic run_cycle(input logic e_ma, input logic e_db);
    logic [DATA_W-1:0] d;
    @(negedge clk);
    check_val("ma_gnt", 32'(ma_gnt), 32'(e_ma));
    check_val("db_gnt", 32'(db_gnt), 32'(e_db));
    check_val("ena", 32'(ena), 32'(e_ma | e_db));
    check_val("wea", 32'(wea), 32'((e_ma & ma_we) | (e_db & db_we)));
    check_val("addra", 32'(addra), e_db ? 32'(db_addr) : 32'(ma_addr));
    check_val("dina", dina, e_db ? db_wdata : ma_wdata);
    check_val("ma_rvalid", 32'(ma_rvalid), 32'(ma_q.size() != 0));
    if (ma_q.size() != 0) begin
      d = ma_q.pop_front();
      check_val("ma_rdata", ma_rdata, d);
    end
    check_val("db_rvalid", 32'(db_rvalid), 32'(db_q.size() != 0));
    if (db_q.size() != 0) begin
      d = db_q.pop_front();
      check_val("db_rdata", db_rdata, d);
    end
    if (e_ma) begin
      if (ma_we) shadow[ma_addr] = ma_wdata;
      else ma_q.push_back(shadow[ma_addr]);
    end
    if (e_db) begin
      if (db_we) shadow[db_addr] = db_wdata;
      else db_q.push_back(shadow[db_addr]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_ma_rvalid"}, 32'(ma_rvalid), 32'd0);
    check_val({tag, "_db_rvalid"}, 32'(db_rvalid), 32'd0);
    check_val({tag, "_gnt"}, 32'({ma_gnt, db_gnt}), 32'd0);
    check_val({tag, "_ena_wea"}, 32'({ena, wea}), 32'd0);
  endtask

  task automatic do_reset();
    ma_req = 1'b0; db_req = 1'b0; ma_we = 1'b0; db_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_quiet("rst");
    @(negedge clk);
    check_quiet("rst_hold");
    rst_n = 1'b1;
    ma_q.delete();
    db_q.delete();
    @(posedge clk);
    #1;
  endtask

  // Both ports read continuously; grants must alternate in bursts of MB.
  task automatic contention(input int n);
    logic e_ma;
    ma_req = 1'b1; ma_we = 1'b0; ma_addr = 7'd0;
    db_req = 1'b1; db_we = 1'b0; db_addr = 7'd64;
    for (int k = 0; k < n; k++) begin
      e_ma = (((k / MB) % 2) == 0);
      run_cycle(e_ma, !e_ma);
      if (e_ma) ma_addr = ma_addr + 7'd1;
      else db_addr = db_addr + 7'd1;
    end
    ma_req = 1'b0; db_req = 1'b0;
    run_cycle(1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; init_mem = 1'b1;
    ma_req = 1'b0; ma_we = 1'b0; ma_addr = 7'd0; ma_wdata = 32'd0;
    db_req = 1'b0; db_we = 1'b0; db_addr = 7'd0; db_wdata = 32'd0;
    for (int i = 0; i < (1 << ADDR_W); i++) shadow[i] = 32'hA500_0000 + 32'(i);
    @(posedge clk);
    #1;
    init_mem = 1'b0;
    do_reset();

    // MA-only write then read of addr 5
    ma_req = 1'b1; ma_we = 1'b1; ma_addr = 7'd5; ma_wdata = 32'hDEAD_BEEF;
    run_cycle(1'b1, 1'b0);
    ma_we = 1'b0;
    run_cycle(1'b1, 1'b0);
    ma_req = 1'b0;
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b0);

    // Continuous contention from reset
    do_reset();
    contention(24);

    // Idle gap clears the burst count; owner MA gets a full burst again
    do_reset();
    ma_req = 1'b1; ma_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ma_addr = 7'(10 + i);
      run_cycle(1'b1, 1'b0);
    end
    ma_req = 1'b0;
    run_cycle(1'b0, 1'b0);
    ma_req = 1'b1; db_req = 1'b1; db_we = 1'b0; db_addr = 7'd20;
    for (int i = 0; i < MB; i++) begin
      ma_addr = 7'(30 + i);
      run_cycle(1'b1, 1'b0);
    end
    ma_req = 1'b0;
    run_cycle(1'b0, 1'b1);
    db_req = 1'b0;
    run_cycle(1'b0, 1'b0);

    // DB alone: ten back-to-back writes, then read addr 7
    db_req = 1'b1; db_we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      db_addr = 7'(i);
      db_wdata = 32'h100 + 32'(i);
      run_cycle(1'b0, 1'b1);
    end
    db_we = 1'b0; db_addr = 7'd7;
    run_cycle(1'b0, 1'b1);
    db_req = 1'b0;
    run_cycle(1'b0, 1'b0);
    check_val("readback_7", shadow[7], 32'h107);

    // Same-cycle MA write and DB read of addr 3
    do_reset();
    ma_req = 1'b1; ma_we = 1'b1; ma_addr = 7'd3; ma_wdata = 32'h1234_5678;
    db_req = 1'b1; db_we = 1'b0; db_addr = 7'd3;
    run_cycle(1'b1, 1'b0);
    ma_req = 1'b0;
    run_cycle(1'b0, 1'b1);
    db_req = 1'b0;
    run_cycle(1'b0, 1'b0);

    // Reset half a cycle after a DB read is granted discards the return
    do_reset();
    db_req = 1'b1; db_we = 1'b0; db_addr = 7'd9;
    run_cycle(1'b0, 1'b1);
    db_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_db_rvalid", 32'(db_rvalid), 32'd0);
    ma_q.delete();
    db_q.delete();
    do_reset();
    contention(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port data memory (32-bit words, 7-bit word address, 1-cycle read latency) between the pipeline's memory-access stage (port MA) and the debug/loader interface (port DB). Grants at most one transfer per cycle with bounded-burst fair arbitration. Drives the memory enable, write enable, address and data pins. Returns read data to the winning port with a registered valid strobe. Sits between the memory-access stage and the data memory primitive; MA stalls on `ma_req & ~ma_gnt`.

## Interface
- `ADDR_W`, 7: memory word-address width.
- `DATA_W`, 32: data width.
- `MAX_BURST`, 4: maximum consecutive transfers one port may take while the other is requesting (≥1).
- `clk` input 1: single clock, rising edge. Also drives `clka`.
- `rst_n` input 1: asynchronous, active-low reset.
- `ma_req`, `ma_we` input 1 each: MA request; write when `ma_we`=1, read otherwise.
- `ma_addr` input ADDR_W: MA address.
- `ma_wdata` input DATA_W: MA write data.
- `ma_gnt` output 1: MA transfer accepted this cycle (combinational).
- `ma_rvalid` output 1: registered; `ma_rdata` is valid this cycle.
- `ma_rdata` output DATA_W: read data for MA.
- `db_req`, `db_we`, `db_addr`, `db_wdata`, `db_gnt`, `db_rvalid`, `db_rdata`: the same signals for the DB port.
- `clka` output 1: equals `clk`.
- `ena` output 1: memory enable.
- `wea` output 1: memory write enable.
- `addra` output ADDR_W: memory address.
- `dina` output DATA_W: memory write data.
- `douta` input DATA_W: memory read data, valid the cycle after a read edge.

## Operation
- Handshake:
  - A requester holds `req`, `we`, `addr` and `wdata` stable until it samples `gnt`=1 at a rising edge.
  - The transfer occurs at that edge.
  - `gnt` never asserts without `req`.
- Registered state:
  - `owner` (0=MA, 1=DB); reset value 0.
  - `burst_cnt`, range 0..MAX_BURST; reset value 0.
- Grant decision, combinational each cycle:
  - Neither port requests: no grant; `ena`=0.
  - One port requests: that port is granted. No burst limit applies.
  - Both request and `burst_cnt` < MAX_BURST: `owner` is granted.
  - Both request and `burst_cnt` == MAX_BURST: the non-owner is granted.
- Memory pins:
  - `ena` = any grant.
  - `wea` = granted port's `we` AND `ena`.
  - `addra` and `dina` come from the granted port.
  - When there is no grant: `wea`=0; `addra`/`dina` take MA's values; `ena`=0.
- State update at each edge:
  - Granted port == `owner`: `burst_cnt` increments, saturating at MAX_BURST.
  - Granted port != `owner`: `owner` ← granted port; `burst_cnt` ← 1.
  - No grant: `owner` holds; `burst_cnt` ← 0.
- Read return:
  - `x_rvalid` ← (x granted AND NOT `x_we`) at each edge.
  - `ma_rdata` = `db_rdata` = `douta`, combinational passthrough. Consumers qualify it with `rvalid`.
  - Writes never produce `rvalid`.
- Reset:
  - `rst_n`=0 asynchronously forces `owner`=0, `burst_cnt`=0, `ma_rvalid`=`db_rvalid`=0.
  - A read granted on the edge before reset asserts returns no `rvalid`; the data is discarded.
  - Grants remain combinational during reset. The requester must keep `req` low while `rst_n`=0; the bench checks this.

## Timing
- Grant latency: 0 cycles. `gnt` is combinational from `req` and registered state.
- Read latency: data and `rvalid` appear 1 cycle after the granting edge.
- Write latency: memory is updated at the granting edge.
- Throughput: one transfer per cycle, total across both ports.
- Simultaneous events:
  - Both ports may have back-to-back grants interleaved.
  - Port A's `rvalid` and port B's grant may coincide in the same cycle.
- Fairness: under continuous contention, the grant pattern is MAX_BURST transfers for one port, then MAX_BURST for the other, repeating.
- Boundaries:
  - `burst_cnt` saturates and never wraps.
  - MAX_BURST=1 gives strict alternation under contention.
  - A single requester is never throttled.
- Reset values of outputs:
  - `ma_rvalid`=`db_rvalid`=0.
  - `ma_gnt`/`db_gnt`/`ena`/`wea` are 0 whenever no `req` is asserted.

## Test plan
- Reset, MA-only access:
  - Stimulus: after reset, MA writes 0xDEADBEEF to addr 5, then reads addr 5.
  - Response: `ma_gnt` is 1 in both cycles; `wea`=1 then 0; one cycle after the read, `ma_rvalid`=1 and `ma_rdata`=0xDEADBEEF; `db_rvalid` stays 0.
- Contention with MAX_BURST=4:
  - Stimulus: both ports issue continuous reads from reset.
  - Response: grants run MA×4, DB×4, MA×4, and so on; each `rvalid` follows its own grant by exactly one cycle; `burst_cnt` never exceeds 4.
- Idle gap:
  - Stimulus: MA is granted 3 times, one idle cycle follows, then both ports request.
  - Response: MA (`owner`) is granted, since `burst_cnt` was reset to 0; DB waits for 4 MA grants.
- Lone requester beyond the burst limit:
  - Stimulus: DB alone issues 10 consecutive writes to addrs 0..9 with data 0x100+i.
  - Response: all 10 are granted back to back; readback of addr 7 returns 0x107.
- Write/read interleave:
  - Stimulus: MA writes addr 3 = 0x12345678 while DB requests a read of addr 3 in the same cycle.
  - Response: MA is granted first (`owner`=0 after reset); DB's read is granted the next cycle and returns 0x12345678.
- Reset mid-read:
  - Stimulus: DB read is granted; `rst_n` is pulled low half a cycle later.
  - Response: `db_rvalid` stays 0; after release, `owner`=0 and `burst_cnt`=0, and a contention test restarts with MA first.
